// File: rtl/d_e_hazard_reg_pkg.sv
// Shared encodings and field helpers for the D->E pipeline register and its hazard logic.
// Tuse/Tnew are 2-bit cycle counts; a Tuse of TUSE_NONE means the operand is never read.
package d_e_hazard_reg_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef logic [1:0] tcyc_t;
  typedef logic [4:0] reg_idx_t;

  localparam tcyc_t TUSE_NONE  = 2'd3;
  localparam tcyc_t TNEW_READY = 2'd0;

  function automatic logic [5:0] field_opc(input logic [DATA_W-1:0] instr);
    return instr[31:26];
  endfunction

  function automatic reg_idx_t field_rs(input logic [DATA_W-1:0] instr);
    return instr[25:21];
  endfunction

  function automatic reg_idx_t field_rt(input logic [DATA_W-1:0] instr);
    return instr[20:16];
  endfunction

  function automatic reg_idx_t field_rd(input logic [DATA_W-1:0] instr);
    return instr[15:11];
  endfunction

  // Tnew as seen one stage later; a result that is already ready stays ready.
  function automatic tcyc_t tnew_age(input tcyc_t tnew);
    return (tnew == TNEW_READY) ? TNEW_READY : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/d_e_hazard_reg_if.sv
// D-stage bundle in, E-stage bundle and hazard status out.
// master = the pipeline around the register, slave = the register itself.
interface d_e_hazard_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  import d_e_hazard_reg_pkg::*;

  logic [WIDTH-1:0] D_instr;
  logic [WIDTH-1:0] D_pc;
  logic [WIDTH-1:0] D_rs_data;
  logic [WIDTH-1:0] D_rt_data;
  logic [WIDTH-1:0] D_ext_imm;
  tcyc_t            D_Tuse_rs;
  tcyc_t            D_Tuse_rt;
  tcyc_t            E_Tnew_in;
  reg_idx_t         E_A3_in;
  logic             flush;

  logic             stall;
  logic [WIDTH-1:0] E_instr;
  logic [WIDTH-1:0] E_pc;
  logic [WIDTH-1:0] E_pc8;
  logic [WIDTH-1:0] E_rs_data;
  logic [WIDTH-1:0] E_rt_data;
  logic [WIDTH-1:0] E_ext_imm;
  logic             E_bubble;
  reg_idx_t         M_A3;
  tcyc_t            M_Tnew;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output D_instr, D_pc, D_rs_data, D_rt_data, D_ext_imm,
           D_Tuse_rs, D_Tuse_rt, E_Tnew_in, E_A3_in, flush,
    input  stall, E_instr, E_pc, E_pc8, E_rs_data, E_rt_data, E_ext_imm,
           E_bubble, M_A3, M_Tnew, stall_cnt
  );

  modport slave (
    input  D_instr, D_pc, D_rs_data, D_rt_data, D_ext_imm,
           D_Tuse_rs, D_Tuse_rt, E_Tnew_in, E_A3_in, flush,
    output stall, E_instr, E_pc, E_pc8, E_rs_data, E_rt_data, E_ext_imm,
           E_bubble, M_A3, M_Tnew, stall_cnt
  );

endinterface

// File: rtl/d_e_hazard_reg_hazard_cmp.sv
// One operand-versus-producer check: hit when a later stage will not have the value
// ready by the time the D-stage instruction needs it. $0 never hazards.
module hazard_cmp
  import d_e_hazard_reg_pkg::*;
(
  input  reg_idx_t src,
  input  tcyc_t    tuse,
  input  reg_idx_t a3,
  input  tcyc_t    tnew,
  output logic     hit
);

  assign hit = (src != 5'd0) && (a3 == src) && (tnew > tuse);

endmodule

// File: rtl/d_e_hazard_reg.sv
// D->E pipeline register with lw-use style stall detection against E and M producers.
// On stall or flush the E slot receives a nop bubble; stall cycles are counted (saturating).
module d_e_hazard_reg
  import d_e_hazard_reg_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               CNT_W     = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic             clk,
  input  logic             reset,
  d_e_hazard_reg_if.slave  bus
);

  reg_idx_t src_reg  [2];
  tcyc_t    src_tuse [2];
  reg_idx_t dst_a3   [2];
  tcyc_t    dst_tnew [2];
  logic [3:0] hit;
  logic       stall_int;
  logic       inject;

  logic [WIDTH-1:0] e_instr_reg, e_pc_reg, e_pc8_reg;
  logic [WIDTH-1:0] e_rs_data_reg, e_rt_data_reg, e_ext_imm_reg;
  logic             e_bubble_reg;
  reg_idx_t         m_a3_reg;
  tcyc_t            m_tnew_reg;
  logic [CNT_W-1:0] stall_cnt_reg;

  // Index 0 = rs, 1 = rt for sources; 0 = E, 1 = M for producers.
  assign src_reg[0]  = field_rs(bus.D_instr[DATA_W-1:0]);
  assign src_reg[1]  = field_rt(bus.D_instr[DATA_W-1:0]);
  assign src_tuse[0] = bus.D_Tuse_rs;
  assign src_tuse[1] = bus.D_Tuse_rt;
  assign dst_a3[0]   = bus.E_A3_in;
  assign dst_a3[1]   = m_a3_reg;
  assign dst_tnew[0] = bus.E_Tnew_in;
  assign dst_tnew[1] = m_tnew_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
      hazard_cmp u_cmp (
        .src  (src_reg[gi % 2]),
        .tuse (src_tuse[gi % 2]),
        .a3   (dst_a3[gi / 2]),
        .tnew (dst_tnew[gi / 2]),
        .hit  (hit[gi])
      );
    end
  endgenerate

  assign stall_int = |hit;
  assign inject    = stall_int | bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_instr_reg   <= WIDTH'(NOP_INSTR);
      e_pc_reg      <= '0;
      e_pc8_reg     <= '0;
      e_rs_data_reg <= '0;
      e_rt_data_reg <= '0;
      e_ext_imm_reg <= '0;
      e_bubble_reg  <= 1'b1;
      m_a3_reg      <= '0;
      m_tnew_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      // M tracking advances every cycle: a bubble in E simply moves on as A3 = 0.
      m_a3_reg   <= bus.E_A3_in;
      m_tnew_reg <= tnew_age(bus.E_Tnew_in);
      if (stall_int && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (inject) begin
        e_instr_reg   <= WIDTH'(NOP_INSTR);
        e_pc_reg      <= '0;
        e_pc8_reg     <= '0;
        e_rs_data_reg <= '0;
        e_rt_data_reg <= '0;
        e_ext_imm_reg <= '0;
        e_bubble_reg  <= 1'b1;
      end else begin
        e_instr_reg   <= bus.D_instr;
        e_pc_reg      <= bus.D_pc;
        e_pc8_reg     <= bus.D_pc + WIDTH'(8);
        e_rs_data_reg <= bus.D_rs_data;
        e_rt_data_reg <= bus.D_rt_data;
        e_ext_imm_reg <= bus.D_ext_imm;
        e_bubble_reg  <= 1'b0;
      end
    end
  end

  assign bus.stall     = stall_int;
  assign bus.E_instr   = e_instr_reg;
  assign bus.E_pc      = e_pc_reg;
  assign bus.E_pc8     = e_pc8_reg;
  assign bus.E_rs_data = e_rs_data_reg;
  assign bus.E_rt_data = e_rt_data_reg;
  assign bus.E_ext_imm = e_ext_imm_reg;
  assign bus.E_bubble  = e_bubble_reg;
  assign bus.M_A3      = m_a3_reg;
  assign bus.M_Tnew    = m_tnew_reg;
  assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_d_e_hazard_reg.sv
// Bench for d_e_hazard_reg: directed vector table, hand sequences and random traffic
// against a behavioural model; a second instance with a 4-bit counter checks saturation.
module tb_d_e_hazard_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] d_instr = '0, d_pc = '0, d_rs = '0, d_rt = '0, d_imm = '0;
  logic [1:0]  tuse_rs = 2'd3, tuse_rt = 2'd3, e_tnew = '0;
  logic [4:0]  e_a3 = '0;
  logic        d_flush = 1'b0;

  d_e_hazard_reg_if #(.WIDTH(32), .CNT_W(32)) bus ();
  d_e_hazard_reg_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  assign bus.D_instr   = d_instr;   assign bus4.D_instr   = d_instr;
  assign bus.D_pc      = d_pc;      assign bus4.D_pc      = d_pc;
  assign bus.D_rs_data = d_rs;      assign bus4.D_rs_data = d_rs;
  assign bus.D_rt_data = d_rt;      assign bus4.D_rt_data = d_rt;
  assign bus.D_ext_imm = d_imm;     assign bus4.D_ext_imm = d_imm;
  assign bus.D_Tuse_rs = tuse_rs;   assign bus4.D_Tuse_rs = tuse_rs;
  assign bus.D_Tuse_rt = tuse_rt;   assign bus4.D_Tuse_rt = tuse_rt;
  assign bus.E_Tnew_in = e_tnew;    assign bus4.E_Tnew_in = e_tnew;
  assign bus.E_A3_in   = e_a3;      assign bus4.E_A3_in   = e_a3;
  assign bus.flush     = d_flush;   assign bus4.flush     = d_flush;

  d_e_hazard_reg #(.WIDTH(32), .CNT_W(32)) dut  (.clk(clk), .reset(rst), .bus(bus));
  d_e_hazard_reg #(.WIDTH(32), .CNT_W(4))  dut4 (.clk(clk), .reset(rst), .bus(bus4));

  int checks = 0;
  int errors = 0;

  // Behavioural model of what E and M should hold.
  logic [31:0] x_instr, x_pc, x_pc8, x_rs, x_rt, x_imm;
  bit          x_bubble;
  int          x_m_a3 = 0, x_m_tnew = 0;
  longint      x_cnt = 0;
  int          x_cnt4 = 0;

  typedef struct {
    logic [31:0] instr, pc, rs, rt, imm;
    logic [1:0]  tuse_rs, tuse_rt, e_tnew;
    logic [4:0]  e_a3;
    bit          flush;
    bit          exp_stall;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // An operand must wait if any pending producer of that register is still
  // further from completion than the operand's slack.
  function automatic bit model_stall();
    int src [2];
    int tu  [2];
    src[0] = int'(d_instr[25:21]); tu[0] = int'(tuse_rs);
    src[1] = int'(d_instr[20:16]); tu[1] = int'(tuse_rt);
    for (int k = 0; k < 2; k++) begin
      if (src[k] == 0) continue;
      if (int'(e_a3) == src[k] && int'(e_tnew) > tu[k]) return 1'b1;
      if (x_m_a3 == src[k] && x_m_tnew > tu[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic set_in(input vec_t v);
    d_instr = v.instr; d_pc = v.pc; d_rs = v.rs; d_rt = v.rt; d_imm = v.imm;
    tuse_rs = v.tuse_rs; tuse_rt = v.tuse_rt; e_tnew = v.e_tnew; e_a3 = v.e_a3;
    d_flush = v.flush;
  endtask

  task automatic step(input bit do_rst, input string tag);
    bit s;
    rst = do_rst;
    #2;
    s = model_stall();
    if (!do_rst || x_m_a3 != 0) chk({tag, ".stall"}, {63'd0, bus.stall}, {63'd0, s});
    @(posedge clk);
    if (do_rst) begin
      x_instr = 32'h0; x_pc = 0; x_pc8 = 0; x_rs = 0; x_rt = 0; x_imm = 0;
      x_bubble = 1; x_m_a3 = 0; x_m_tnew = 0; x_cnt = 0; x_cnt4 = 0;
    end else begin
      if (s) begin
        if (x_cnt < 64'hFFFF_FFFF) x_cnt = x_cnt + 1;
        if (x_cnt4 < 15) x_cnt4 = x_cnt4 + 1;
      end
      if (s || d_flush) begin
        x_instr = 32'h0; x_pc = 0; x_pc8 = 0; x_rs = 0; x_rt = 0; x_imm = 0; x_bubble = 1;
      end else begin
        x_instr = d_instr; x_pc = d_pc; x_pc8 = d_pc + 32'd8;
        x_rs = d_rs; x_rt = d_rt; x_imm = d_imm; x_bubble = 0;
      end
      x_m_a3   = int'(e_a3);
      x_m_tnew = (e_tnew == 0) ? 0 : int'(e_tnew) - 1;
    end
    #1;
    chk({tag, ".E_instr"},   bus.E_instr,   x_instr);
    chk({tag, ".E_pc"},      bus.E_pc,      x_pc);
    chk({tag, ".E_pc8"},     bus.E_pc8,     x_pc8);
    chk({tag, ".E_rs_data"}, bus.E_rs_data, x_rs);
    chk({tag, ".E_rt_data"}, bus.E_rt_data, x_rt);
    chk({tag, ".E_ext_imm"}, bus.E_ext_imm, x_imm);
    chk({tag, ".E_bubble"},  {63'd0, bus.E_bubble}, {63'd0, x_bubble});
    chk({tag, ".M_A3"},      {59'd0, bus.M_A3},     64'(x_m_a3));
    chk({tag, ".M_Tnew"},    {62'd0, bus.M_Tnew},   64'(x_m_tnew));
    chk({tag, ".stall_cnt"}, {32'd0, bus.stall_cnt}, x_cnt);
    chk({tag, ".stall_cnt4"}, {60'd0, bus4.stall_cnt}, 64'(x_cnt4));
    $display("[%0t] %s rst=%0b stall=%0b flush=%0b E_instr=%h bubble=%0b M_A3=%0d M_Tnew=%0d cnt=%0d",
             $time, tag, do_rst, s, d_flush, bus.E_instr, bus.E_bubble, bus.M_A3, bus.M_Tnew, bus.stall_cnt);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    d_instr = 0; d_pc = 0; d_rs = 0; d_rt = 0; d_imm = 0;
    tuse_rs = 2'd3; tuse_rt = 2'd3; e_tnew = 0; e_a3 = 0; d_flush = 0;
  endtask

  initial begin
    // instr, pc, rs, rt, imm, tuse_rs, tuse_rt, e_tnew, e_a3, flush, exp_stall
    vecs[0]  = '{32'h0101_4821, 32'h3000, 32'h11, 32'h22, 32'h0,  2'd1, 2'd1, 2'd2, 5'd8, 1'b0, 1'b1};
    vecs[1]  = '{32'h0101_4821, 32'h3000, 32'h11, 32'h22, 32'h0,  2'd1, 2'd1, 2'd0, 5'd0, 1'b0, 1'b0};
    vecs[2]  = '{32'h8C05_0004, 32'h3000, 32'h0,  32'h55, 32'h4,  2'd0, 2'd3, 2'd2, 5'd0, 1'b0, 1'b0};
    vecs[3]  = '{32'h10A0_0003, 32'h3004, 32'hA5, 32'h0,  32'h3,  2'd0, 2'd0, 2'd2, 5'd5, 1'b0, 1'b1};
    vecs[4]  = '{32'h10A0_0003, 32'h3004, 32'hA5, 32'h0,  32'h3,  2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1};
    vecs[5]  = '{32'h10A0_0003, 32'h3004, 32'hA5, 32'h0,  32'h3,  2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b0};
    vecs[6]  = '{32'h2464_0001, 32'h3008, 32'h33, 32'h44, 32'h1,  2'd1, 2'd3, 2'd1, 5'd3, 1'b1, 1'b0};
    vecs[7]  = '{32'h0067_1021, 32'h300C, 32'h66, 32'h77, 32'h0,  2'd1, 2'd1, 2'd2, 5'd7, 1'b1, 1'b1};
    vecs[8]  = '{32'h1007_0002, 32'h3010, 32'h0,  32'h77, 32'h2,  2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 1'b1};
    vecs[9]  = '{32'h00E0_0025, 32'hFFFF_FFFC, 32'h99, 32'h0, 32'h7, 2'd3, 2'd3, 2'd3, 5'd7, 1'b0, 1'b0};
    vecs[10] = '{32'h00E0_0821, 32'h3018, 32'hBB, 32'h0,  32'h0,  2'd1, 2'd1, 2'd0, 5'd0, 1'b0, 1'b1};

    // Reset held two cycles.
    idle_inputs();
    step(1'b1, "reset0");
    step(1'b1, "reset1");
    #2;
    chk("post_reset.stall", {63'd0, bus.stall}, 64'd0);

    // Directed table: lw-use, $0 reads, M-stage hazard, flush, flush+stall, Tuse none.
    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i]);
      #1;
      chk($sformatf("vec%0d.table_stall", i), {63'd0, bus.stall}, {63'd0, vecs[i].exp_stall});
      step(1'b0, $sformatf("vec%0d", i));
    end
    chk("pc8_wrap", bus.E_pc8, 64'h0);

    // Reset landing on the second cycle of a lw-use stall.
    idle_inputs();
    step(1'b1, "r5_reset");
    set_in(vecs[3]);
    step(1'b0, "r5_stall1");
    e_tnew = 0; e_a3 = 0;
    #1;
    chk("r5_stall2_live", {63'd0, bus.stall}, 64'd1);
    step(1'b1, "r5_reset_in_stall");
    chk("r5_cnt_zero", {32'd0, bus.stall_cnt}, 64'd0);
    step(1'b0, "r5_after");

    // 20 forced stall cycles: the 4-bit counter must pin at 15.
    set_in(vecs[0]);
    e_tnew = 2'd2; e_a3 = 5'd8; tuse_rs = 2'd0;
    for (int i = 0; i < 20; i++) step(1'b0, $sformatf("sat%0d", i));
    chk("sat_cnt4", {60'd0, bus4.stall_cnt}, 64'd15);
    chk("sat_cnt32", {32'd0, bus.stall_cnt}, 64'd20);

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 300; i++) begin
      d_instr = $urandom;
      d_instr[25:21] = 5'($urandom_range(0, 3));
      d_instr[20:16] = 5'($urandom_range(0, 3));
      d_pc = $urandom; d_rs = $urandom; d_rt = $urandom; d_imm = $urandom;
      tuse_rs = 2'($urandom_range(0, 3));
      tuse_rt = 2'($urandom_range(0, 3));
      e_tnew  = 2'($urandom_range(0, 3));
      e_a3    = 5'($urandom_range(0, 3));
      d_flush = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 39) == 0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
